mod_div_counter: RTL and testbench
==================================

Name: mod_div_counter

Overview:
Free-running modulo-N cycle counter. Output `cnt` steps 0,1,…,div-1 and then returns to 0, one step per clock. Other blocks derive timing from it: `cnt==0` once per period, and `cnt%K==0` for sub-ticks. With div=100000000 on the 100 MHz board clock, the period is 1 s. The divisor is a run-time input, not a parameter, so it can be driven by a constant or by logic.

Parameters:
WIDTH, 32, bit width of `cnt` and `div`.

Ports:
clk  input  1  system clock (100 MHz board clock); all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
en  input  1  count enable; when low, `cnt` holds. Tie high for free-running use.
div  input  WIDTH  modulus (period in clock cycles); sampled every cycle.
cnt  output  WIDTH  current count, registered.
wrap  output  1  registered pulse; high for exactly the cycle in which `cnt==0` was just entered by wrap-around (not by reset).

Behaviour:
- Reset: rst_n low clears immediately, without waiting for clk: cnt=0, wrap=0. Assertion mid-count aborts the sequence.
- After rst_n rises, the first rising edge with en=1 gives cnt=1, assuming div>=2.
- Per rising edge with en=1, let `last` be true when cnt >= div-1, computed in WIDTH-bit unsigned arithmetic with div>=2.
  - If `last`: next cnt=0, next wrap=1.
  - Otherwise: next cnt=cnt+1, next wrap=0.
- The `>=` compare is required, not `==`. If div is lowered below the current cnt, the counter wraps to 0 on the next enabled edge. It never runs to 2^WIDTH.
- div==1: cnt stays 0; wrap=1 on every enabled edge.
- div==0: full-range free-run. cnt counts to 2^WIDTH-1 and then to 0; wrap=1 on that edge only.
- en=0: cnt holds its value; wrap=0 on that edge. Changes to div while disabled take effect on the next enabled edge.
- div raised while counting: counting continues from the current cnt up to the new div-1.
- Period with a constant div>=1 and en=1: exactly div cycles between successive wrap pulses. Each value 0..div-1 appears for one cycle.
- No combinational path from any input to `cnt` or `wrap`. Latency from an enabled edge to the updated `cnt` is 0 cycles; it is visible immediately after that edge.
- Simultaneous reset and clock edge: reset wins.
- Synthesizable. No initial blocks are relied upon; reset defines the state.

Test Plan:
- Reset: hold rst_n=0 with div=5 and en=1 for 3 clocks -> cnt=0, wrap=0. Drop rst_n low asynchronously mid-count at cnt=3 -> cnt=0 before the next edge.
- Basic wrap: div=5, en=1, release reset -> cnt sequence 1,2,3,4,0,1…. wrap=1 only in cycles where cnt=0 after 4. Spacing between wrap pulses is 5 cycles.
- Enable hold: div=10; deassert en at cnt=6 for 4 cycles -> cnt stays 6 and wrap=0. Re-enable -> 7,8,9,0.
- Divisor shrink: div=100 with cnt=50; change div to 20 -> next cnt=0 with wrap=1. Following period is 20 cycles.
- Edge divisors:
  - div=1 -> cnt constantly 0, wrap=1 every cycle.
  - div=0 with cnt forced near top (run from reset with WIDTH=8) -> cnt goes 254,255,0, with wrap=1 on the 255->0 edge.
- Board-rate check: div=100000000 -> first wrap at cycle 100000000 after reset release. cnt%100000==0 occurs 1000 times per period.

Source files
------------

// File: rtl/mod_div_counter.sv
// mod_div_counter
// Free-running modulo-N cycle counter with a run-time divisor.
// cnt steps 0..div-1 and wraps to 0. wrap pulses for one cycle when cnt
// re-enters 0 by wrap-around. A reset does not raise wrap.
// Special divisors:
//   div == 1 : cnt stays 0 and wrap is high on every enabled edge.
//   div == 0 : cnt runs the full 2^WIDTH range.
// The terminal compare is ">=" rather than "==". If div drops below the
// current count, the counter wraps on the next enabled edge and never runs
// away to 2^WIDTH.
module mod_div_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  logic [WIDTH-1:0] r_cnt;
  logic             r_wrap;

  logic [WIDTH-1:0] w_div_m1;
  logic             w_last;
  logic [WIDTH-1:0] w_cnt_inc;
  logic [WIDTH-1:0] w_cnt_nxt;

  // Terminal count is div-1 in modular WIDTH-bit arithmetic. For div==0 this
  // is all-ones, which gives the full-range free-run. For div==1 it is 0, so
  // every enabled edge is terminal.
  assign w_div_m1  = div - WIDTH'(1);
  assign w_last    = (r_cnt >= w_div_m1);
  assign w_cnt_inc = r_cnt + WIDTH'(1);
  assign w_cnt_nxt = w_last ? '0 : w_cnt_inc;

  // Count register and wrap pulse. Both are registered, so no input reaches
  // an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else if (en) begin
      r_cnt  <= w_cnt_nxt;
      r_wrap <= w_last;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign cnt  = r_cnt;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_mod_div_counter.sv
// Self-checking bench for mod_div_counter.
// A reference model pushes expected (cnt, wrap) pairs into a queue as each
// cycle's stimulus is driven. The pairs are popped and compared once the DUT
// has clocked. Fixed-value checks cover the specific sequences.
module tb_mod_div_counter;

  typedef struct {
    logic [31:0] cnt;
    logic        wrap;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] div;
  logic [31:0] cnt;
  logic        wrap;

  logic        rst8_n;
  logic        en8;
  logic [7:0]  div8;
  logic [7:0]  cnt8;
  logic        wrap8;

  int   n_vec;
  int   n_err;
  int   cyc;
  exp_t sb_q[$];
  logic [31:0] m_cnt;
  logic [31:0] obs_cnt;
  logic        obs_wrap;

  mod_div_counter #(.WIDTH(32)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .div  (div),
    .cnt  (cnt),
    .wrap (wrap)
  );

  mod_div_counter #(.WIDTH(8)) u_dut8 (
    .clk  (clk),
    .rst_n(rst8_n),
    .en   (en8),
    .div  (div8),
    .cnt  (cnt8),
    .wrap (wrap8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge with the inputs already driven. The model predicts
  // the result, the DUT is clocked, and the scoreboard is checked. The task
  // returns at the following negedge.
  task automatic step();
    exp_t e;
    exp_t p;
    if (!rst_n) begin
      m_cnt  = 32'd0;
      e.cnt  = 32'd0;
      e.wrap = 1'b0;
    end else if (en) begin
      if (m_cnt >= div - 32'd1) begin
        e.cnt  = 32'd0;
        e.wrap = 1'b1;
      end else begin
        e.cnt  = m_cnt + 32'd1;
        e.wrap = 1'b0;
      end
      m_cnt = e.cnt;
    end else begin
      e.cnt  = m_cnt;
      e.wrap = 1'b0;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    obs_cnt  = cnt;
    obs_wrap = wrap;
    p = sb_q.pop_front();
    chk("sb_cnt", {31'd0, 1'b0} | cnt, p.cnt);
    chk("sb_wrap", {31'd0, wrap}, {31'd0, p.wrap});
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_cnt = 32'd0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] seq5 [10];
    int last_wrap;
    int gap;
    int hits;
    int first_wrap;
    n_vec  = 0;
    n_err  = 0;
    cyc    = 0;
    m_cnt  = 32'd0;
    rst_n  = 1'b0;
    en     = 1'b1;
    div    = 32'd5;
    rst8_n = 1'b0;
    en8    = 1'b1;
    div8   = 8'd0;
    @(negedge clk);

    // Reset held for three clocks with div=5 and en=1.
    for (int i = 0; i < 3; i++) step();
    chk("rst_cnt", cnt, 32'd0);
    chk("rst_wrap", {31'd0, wrap}, 32'd0);

    // Basic wrap with div=5.
    seq5 = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0};
    rst_n = 1'b1;
    last_wrap = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("seq5_cnt", obs_cnt, seq5[i]);
      chk("seq5_wrap", {31'd0, obs_wrap}, (seq5[i] == 32'd0) ? 32'd1 : 32'd0);
      if (obs_wrap) begin
        if (last_wrap >= 0) chk("seq5_gap", 32'(i - last_wrap), 32'd5);
        last_wrap = i;
      end
    end

    // Asynchronous reset assertion mid-count at cnt=3.
    do_reset();
    for (int i = 0; i < 3; i++) step();
    chk("pre_async", obs_cnt, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_cnt", cnt, 32'd0);
    chk("async_wrap", {31'd0, wrap}, 32'd0);
    m_cnt = 32'd0;
    @(negedge clk);
    step();
    rst_n = 1'b1;

    // Enable hold with div=10 at cnt=6.
    div = 32'd10;
    for (int i = 0; i < 6; i++) step();
    chk("hold_pre", obs_cnt, 32'd6);
    en = 1'b0;
    div = 32'd3;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_cnt", obs_cnt, 32'd6);
      chk("hold_wrap", {31'd0, obs_wrap}, 32'd0);
    end
    div = 32'd10;
    en  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("resume_cnt", obs_cnt, (i == 3) ? 32'd0 : 32'(7 + i));
      chk("resume_wrap", {31'd0, obs_wrap}, (i == 3) ? 32'd1 : 32'd0);
    end

    // Divisor shrinks below the current count.
    do_reset();
    div = 32'd100;
    for (int i = 0; i < 50; i++) step();
    chk("shrink_pre", obs_cnt, 32'd50);
    div = 32'd20;
    step();
    chk("shrink_cnt", obs_cnt, 32'd0);
    chk("shrink_wrap", {31'd0, obs_wrap}, 32'd1);
    gap = 0;
    do begin
      step();
      gap++;
    end while (!obs_wrap && gap < 64);
    chk("shrink_period", 32'(gap), 32'd20);

    // Divisor raised while counting.
    do_reset();
    div = 32'd5;
    for (int i = 0; i < 3; i++) step();
    div = 32'd8;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("raise_cnt", obs_cnt, (i == 4) ? 32'd0 : 32'(4 + i));
    end

    // div=1: the count stays at 0 and wrap fires every cycle.
    div = 32'd1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("div1_cnt", obs_cnt, 32'd0);
      chk("div1_wrap", {31'd0, obs_wrap}, 32'd1);
    end

    // Scaled board-rate check with div=1000 and sub-tick K=100.
    do_reset();
    div = 32'd1000;
    hits = 0;
    first_wrap = -1;
    for (int i = 1; i <= 1000; i++) begin
      step();
      if (obs_cnt % 100 == 0) hits++;
      if (obs_wrap && first_wrap < 0) first_wrap = i;
    end
    chk("rate_first_wrap", 32'(first_wrap), 32'd1000);
    chk("rate_subticks", 32'(hits), 32'd10);

    // div=0 full-range run on the 8-bit instance.
    en = 1'b0;
    rst8_n = 1'b1;
    for (int i = 0; i < 254; i++) @(posedge clk);
    #1;
    chk("full_254", {24'd0, cnt8}, 32'd254);
    @(posedge clk); #1;
    chk("full_255", {24'd0, cnt8}, 32'd255);
    chk("full_255_wrap", {31'd0, wrap8}, 32'd0);
    @(posedge clk); #1;
    chk("full_0", {24'd0, cnt8}, 32'd0);
    chk("full_0_wrap", {31'd0, wrap8}, 32'd1);
    @(posedge clk); #1;
    chk("full_1_wrap", {31'd0, wrap8}, 32'd0);

    if (sb_q.size() != 0) chk("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
